// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator with retrigger, age-based stealing,
// sustain pedal and All-Notes-Off; per-voice outputs registered one cycle after each message.
module voice_allocator #(
  parameter int         VOICES    = 4,
  parameter int         AGE_WIDTH = 8,
  parameter logic [3:0] CHANNEL   = 4'd0,
  parameter bit         OMNI      = 1'b1
) (
  input  logic                  clock_50_000_000,
  input  logic                  reset_l,
  input  logic                  msg_valid,
  input  logic [3:0]            msg_type,
  input  logic [3:0]            msg_channel,
  input  logic [6:0]            data_byte1,
  input  logic [6:0]            data_byte2,
  output logic [VOICES*7-1:0]   voice_note,
  output logic [VOICES*7-1:0]   voice_velocity,
  output logic [VOICES-1:0]     voice_on,
  output logic [VOICES-1:0]     voice_update,
  output logic                  steal
);

  typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, SUSTAINED = 2'd2} voice_state_t;

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  voice_state_t           state_q [VOICES];
  voice_state_t           state_d [VOICES];
  logic [6:0]             note_q  [VOICES];
  logic [6:0]             note_d  [VOICES];
  logic [6:0]             vel_q   [VOICES];
  logic [6:0]             vel_d   [VOICES];
  logic [AGE_WIDTH-1:0]   age_q   [VOICES];
  logic [AGE_WIDTH-1:0]   age_d   [VOICES];
  logic                   pedal_q, pedal_d;
  logic [VOICES-1:0]      update_q, update_d;
  logic                   steal_q, steal_d;

  logic accept, note_on, note_off, cc_msg;
  assign accept   = msg_valid && (OMNI || msg_channel == CHANNEL);
  assign note_on  = accept && msg_type == 4'h9 && data_byte2 != 7'd0;
  assign note_off = accept && (msg_type == 4'h8 || (msg_type == 4'h9 && data_byte2 == 7'd0));
  assign cc_msg   = accept && msg_type == 4'hB;

  // Candidate scan: strict '>' on age keeps the lowest index on ties.
  logic                 match_found, idle_found, sus_found, steal_sel;
  int                   match_idx, idle_idx, sus_idx, held_idx, target;
  logic [AGE_WIDTH-1:0] sus_age, held_age;

  always_comb begin
    match_found = 1'b0;
    match_idx   = 0;
    idle_found  = 1'b0;
    idle_idx    = 0;
    sus_found   = 1'b0;
    sus_idx     = 0;
    sus_age     = '0;
    held_idx    = 0;
    held_age    = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (!match_found && state_q[i] != IDLE && note_q[i] == data_byte1) begin
        match_found = 1'b1;
        match_idx   = i;
      end
      if (!idle_found && state_q[i] == IDLE) begin
        idle_found = 1'b1;
        idle_idx   = i;
      end
      if (state_q[i] == SUSTAINED && (!sus_found || age_q[i] > sus_age)) begin
        sus_found = 1'b1;
        sus_idx   = i;
        sus_age   = age_q[i];
      end
      if (state_q[i] == HELD && (age_q[i] > held_age || held_idx == i && held_age == '0)) begin
        held_idx = i;
        held_age = age_q[i];
      end
    end
    steal_sel = !match_found && !idle_found;
    target    = match_found ? match_idx : idle_found ? idle_idx : sus_found ? sus_idx : held_idx;
  end

  always_comb begin
    state_d  = state_q;
    note_d   = note_q;
    vel_d    = vel_q;
    age_d    = age_q;
    pedal_d  = pedal_q;
    update_d = '0;
    steal_d  = 1'b0;
    if (note_on) begin
      steal_d = steal_sel;
      for (int i = 0; i < VOICES; i++) begin
        if (i == target) begin
          state_d[i]  = HELD;
          note_d[i]   = data_byte1;
          vel_d[i]    = data_byte2;
          age_d[i]    = '0;
          update_d[i] = 1'b1;
        end else if (state_q[i] != IDLE && age_q[i] != AGE_MAX) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end else if (note_off) begin
      for (int i = 0; i < VOICES; i++) begin
        if (state_q[i] == HELD && note_q[i] == data_byte1) begin
          state_d[i]  = pedal_q ? SUSTAINED : IDLE;
          update_d[i] = !pedal_q;
        end
      end
    end else if (cc_msg && data_byte1 == 7'd64) begin
      pedal_d = data_byte2[6];
      if (pedal_q && !data_byte2[6]) begin
        for (int i = 0; i < VOICES; i++) begin
          if (state_q[i] == SUSTAINED) begin
            state_d[i]  = IDLE;
            update_d[i] = 1'b1;
          end
        end
      end
    end else if (cc_msg && data_byte1 == 7'd123) begin
      for (int i = 0; i < VOICES; i++) begin
        if (state_q[i] != IDLE) begin
          state_d[i]  = IDLE;
          update_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < VOICES; i++) begin
        state_q[i] <= IDLE;
        note_q[i]  <= '0;
        vel_q[i]   <= '0;
        age_q[i]   <= '0;
      end
      pedal_q  <= 1'b0;
      update_q <= '0;
      steal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      age_q    <= age_d;
      pedal_q  <= pedal_d;
      update_q <= update_d;
      steal_q  <= steal_d;
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_out
    assign voice_note[g*7 +: 7]     = note_q[g];
    assign voice_velocity[g*7 +: 7] = vel_q[g];
    assign voice_on[g]              = state_q[g] != IDLE;
  end

  assign voice_update = update_q;
  assign steal        = steal_q;

endmodule
